// File: rtl/mipi_rx_cfg_sequencer_if.sv
// ---------------------------------------------------------------------------
// mipi_rx_cfg_sequencer_if
// Purpose : AXI4-Lite bus bundle between the configuration sequencer and the
//           mipi_rx_to_video S00_AXI register file.
// Signals : aw*  - write address channel (addr, prot, valid/ready)
//           w*   - write data channel (data, strobe, valid/ready)
//           b*   - write response channel (resp, valid/ready)
//           ar*  - read address channel (addr, prot, valid/ready)
//           r*   - read data channel (data, resp, valid/ready)
// Modports: master (sequencer side), slave (register file side).
// ---------------------------------------------------------------------------
interface mipi_rx_cfg_sequencer_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/mipi_rx_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// mipi_rx_cfg_sequencer
// Purpose : AXI4-Lite master that replays a table of {reg_addr, reg_data}
//           entries into the mipi_rx_to_video S00_AXI register file, one
//           outstanding transaction at a time, launched by a single start pulse.
// Ports   : ACLK, ARESET      clock, asynchronous active-high reset
//           tbl_we/waddr/wdata table load port (ignored while busy)
//           start, num_entries launch pulse and entry count (clamped to depth)
//           busy, done, error  sequence status (done/error are 1-cycle pulses)
//           err_code/err_index 0 none, 1 bad resp, 2 readback mismatch,
//                              3 timeout; failing entry; held until next start
//           m_axi              AXI4-Lite master (mipi_rx_cfg_sequencer_if)
// Option  : define CFG_READBACK_EN to read back and compare every write.
// ---------------------------------------------------------------------------
module mipi_rx_cfg_sequencer #(
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int TBL_DEPTH          = 16,
  parameter int TIMEOUT_CYCLES     = 256,
  localparam int TBL_AW            = $clog2(TBL_DEPTH),
  localparam int ENT_W             = C_M_AXI_ADDR_WIDTH + C_M_AXI_DATA_WIDTH
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  tbl_we,
  input  logic [TBL_AW-1:0]     tbl_waddr,
  input  logic [ENT_W-1:0]      tbl_wdata,
  input  logic                  start,
  input  logic [TBL_AW:0]       num_entries,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic [TBL_AW-1:0]     err_index,
  mipi_rx_cfg_sequencer_if.master m_axi
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TBL_AW:0]   DEPTH_N  = (TBL_AW+1)'(TBL_DEPTH);
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_RESP = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd3;
`ifdef CFG_READBACK_EN
  localparam logic [1:0] ERR_CMP  = 2'd2;
`endif

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0, ST_FETCH = 3'd1, ST_WRITE = 3'd2, ST_WRESP = 3'd3,
    ST_READ  = 3'd4, ST_RDATA = 3'd5, ST_CHECK = 3'd6, ST_NEXT  = 3'd7
  } state_t;

  logic [ENT_W-1:0]  tbl_mem [TBL_DEPTH];
  logic [ENT_W-1:0]  entry_r;
  state_t            state_r, state_s;
  logic [TBL_AW-1:0] idx_r, idx_s, err_index_r, err_index_s;
  logic [TBL_AW:0]   n_r, n_s, idx_inc_s;
  logic [TMO_W-1:0]  tmo_r, tmo_s;
  logic              awvalid_r, awvalid_s, wvalid_r, wvalid_s, bready_r, bready_s;
  logic              busy_r, busy_s, done_r, done_s, error_r, error_s;
  logic [1:0]        err_code_r, err_code_s, fail_code_s;
  logic              fail_s, tmo_hit_s, hs_state_s;
  logic [C_M_AXI_ADDR_WIDTH-1:0] entry_addr_s;
  logic [C_M_AXI_DATA_WIDTH-1:0] entry_data_s;
`ifdef CFG_READBACK_EN
  logic              arvalid_r, arvalid_s, rready_r, rready_s;
  logic [C_M_AXI_DATA_WIDTH-1:0] rdata_r, rdata_s;
`endif

  assign entry_addr_s = entry_r[ENT_W-1 -: C_M_AXI_ADDR_WIDTH];
  assign entry_data_s = entry_r[C_M_AXI_DATA_WIDTH-1:0];
  assign idx_inc_s    = {1'b0, idx_r} + (TBL_AW+1)'(1);
  assign tmo_hit_s    = (tmo_r == TMO_LAST);
  assign hs_state_s   = (state_r inside {ST_WRITE, ST_WRESP, ST_READ, ST_RDATA});

  // Table RAM and its registered read port; the RAM survives reset by design.
  always_ff @(posedge ACLK) begin
    if (tbl_we && (state_r == ST_IDLE)) tbl_mem[tbl_waddr] <= tbl_wdata;
    if (state_r == ST_FETCH) entry_r <= tbl_mem[idx_r];
  end

  // Next-state and next-output logic; failures are funnelled through fail_s.
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    n_s         = n_r;
    tmo_s       = tmo_r;
    awvalid_s   = awvalid_r;
    wvalid_s    = wvalid_r;
    bready_s    = bready_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    error_s     = 1'b0;
    err_code_s  = err_code_r;
    err_index_s = err_index_r;
    fail_s      = 1'b0;
    fail_code_s = ERR_NONE;
`ifdef CFG_READBACK_EN
    arvalid_s   = arvalid_r;
    rready_s    = rready_r;
    rdata_s     = rdata_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          idx_s = {TBL_AW{1'b0}};
          n_s   = (num_entries > DEPTH_N) ? DEPTH_N : num_entries;
          if (num_entries == (TBL_AW+1)'(0)) begin
            done_s = 1'b1;
          end else begin
            err_code_s  = ERR_NONE;
            err_index_s = {TBL_AW{1'b0}};
            busy_s      = 1'b1;
            state_s     = ST_FETCH;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        // entry_r loads on this same edge, so address/data are valid with VALID.
        awvalid_s = 1'b1;
        wvalid_s  = 1'b1;
        state_s   = ST_WRITE;
      end
      ST_WRITE: begin
        awvalid_s = awvalid_r & ~m_axi.awready;
        wvalid_s  = wvalid_r & ~m_axi.wready;
        if (!awvalid_s && !wvalid_s) begin
          bready_s = 1'b1;
          state_s  = ST_WRESP;
        end else if (tmo_hit_s) begin
          fail_s      = 1'b1;
          fail_code_s = ERR_TMO;
        end else begin
          state_s = ST_WRITE;
        end
      end
      ST_WRESP: begin
        if (m_axi.bvalid && bready_r) begin
          bready_s = 1'b0;
          if (m_axi.bresp != 2'b00) begin
            fail_s      = 1'b1;
            fail_code_s = ERR_RESP;
          end else begin
`ifdef CFG_READBACK_EN
            arvalid_s = 1'b1;
            state_s   = ST_READ;
`else
            state_s   = ST_NEXT;
`endif
          end
        end else if (tmo_hit_s) begin
          fail_s      = 1'b1;
          fail_code_s = ERR_TMO;
        end else begin
          state_s = ST_WRESP;
        end
      end
`ifdef CFG_READBACK_EN
      ST_READ: begin
        if (m_axi.arready) begin
          arvalid_s = 1'b0;
          rready_s  = 1'b1;
          state_s   = ST_RDATA;
        end else if (tmo_hit_s) begin
          fail_s      = 1'b1;
          fail_code_s = ERR_TMO;
        end else begin
          state_s = ST_READ;
        end
      end
      ST_RDATA: begin
        if (m_axi.rvalid && rready_r) begin
          rready_s = 1'b0;
          if (m_axi.rresp != 2'b00) begin
            fail_s      = 1'b1;
            fail_code_s = ERR_RESP;
          end else begin
            rdata_s = m_axi.rdata;
            state_s = ST_CHECK;
          end
        end else if (tmo_hit_s) begin
          fail_s      = 1'b1;
          fail_code_s = ERR_TMO;
        end else begin
          state_s = ST_RDATA;
        end
      end
      ST_CHECK: begin
        if (rdata_r != entry_data_s) begin
          fail_s      = 1'b1;
          fail_code_s = ERR_CMP;
        end else begin
          state_s = ST_NEXT;
        end
      end
`endif
      ST_NEXT: begin
        if (idx_inc_s == n_r) begin
          done_s  = 1'b1;
          busy_s  = 1'b0;
          state_s = ST_IDLE;
        end else begin
          idx_s   = idx_inc_s[TBL_AW-1:0];
          state_s = ST_FETCH;
        end
      end
      default: begin
        busy_s    = 1'b0;
        awvalid_s = 1'b0;
        wvalid_s  = 1'b0;
        bready_s  = 1'b0;
        state_s   = ST_IDLE;
      end
    endcase

    // On any failure every handshake line drops at once, even mid-transfer.
    if (fail_s) begin
      state_s     = ST_IDLE;
      busy_s      = 1'b0;
      error_s     = 1'b1;
      err_code_s  = fail_code_s;
      err_index_s = idx_r;
      awvalid_s   = 1'b0;
      wvalid_s    = 1'b0;
      bready_s    = 1'b0;
`ifdef CFG_READBACK_EN
      arvalid_s   = 1'b0;
      rready_s    = 1'b0;
`endif
      tmo_s       = {TMO_W{1'b0}};
    end else if (state_s != state_r) begin
      tmo_s = {TMO_W{1'b0}};
    end else if (hs_state_s) begin
      tmo_s = tmo_r + TMO_W'(1);
    end else begin
      tmo_s = tmo_r;
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_r     <= ST_IDLE;
      idx_r       <= {TBL_AW{1'b0}};
      n_r         <= {(TBL_AW+1){1'b0}};
      tmo_r       <= {TMO_W{1'b0}};
      awvalid_r   <= 1'b0;
      wvalid_r    <= 1'b0;
      bready_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
      err_code_r  <= ERR_NONE;
      err_index_r <= {TBL_AW{1'b0}};
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      n_r         <= n_s;
      tmo_r       <= tmo_s;
      awvalid_r   <= awvalid_s;
      wvalid_r    <= wvalid_s;
      bready_r    <= bready_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      error_r     <= error_s;
      err_code_r  <= err_code_s;
      err_index_r <= err_index_s;
    end
  end

`ifdef CFG_READBACK_EN
  // Readback channel handshake registers and captured read data.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      arvalid_r <= 1'b0;
      rready_r  <= 1'b0;
      rdata_r   <= {C_M_AXI_DATA_WIDTH{1'b0}};
    end else begin
      arvalid_r <= arvalid_s;
      rready_r  <= rready_s;
      rdata_r   <= rdata_s;
    end
  end

  assign m_axi.arvalid = arvalid_r;
  assign m_axi.rready  = rready_r;
`else
  logic unused_rd_s;
  assign unused_rd_s   = ^{m_axi.arready, m_axi.rvalid, m_axi.rresp, m_axi.rdata};
  assign m_axi.arvalid = 1'b0;
  assign m_axi.rready  = 1'b0;
`endif

  assign m_axi.awaddr  = entry_addr_s;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = awvalid_r;
  assign m_axi.wdata   = entry_data_s;
  assign m_axi.wstrb   = {(C_M_AXI_DATA_WIDTH/8){1'b1}};
  assign m_axi.wvalid  = wvalid_r;
  assign m_axi.bready  = bready_r;
  assign m_axi.araddr  = entry_addr_s;
  assign m_axi.arprot  = 3'b000;

  assign busy      = busy_r;
  assign done      = done_r;
  assign error     = error_r;
  assign err_code  = err_code_r;
  assign err_index = err_index_r;

endmodule

// File: tb/tb_mipi_rx_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mipi_rx_cfg_sequencer
// Directed bench for mipi_rx_cfg_sequencer with a zero-wait AXI4-Lite slave
// model that can stall AWREADY, inject SLVERR on a chosen write, and corrupt
// a chosen readback. Works with or without CFG_READBACK_EN.
// ---------------------------------------------------------------------------
module tb_mipi_rx_cfg_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        tbl_we;
  logic [3:0]  tbl_waddr;
  logic [35:0] tbl_wdata;
  logic        start;
  logic [4:0]  num_entries;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [3:0]  err_index;

  int n_checks = 0;
  int n_fails  = 0;

`ifdef CFG_READBACK_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 4;
`endif

  mipi_rx_cfg_sequencer_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) axi ();

  mipi_rx_cfg_sequencer dut (
    .ACLK(clk), .ARESET(rst),
    .tbl_we(tbl_we), .tbl_waddr(tbl_waddr), .tbl_wdata(tbl_wdata),
    .start(start), .num_entries(num_entries),
    .busy(busy), .done(done), .error(error),
    .err_code(err_code), .err_index(err_index),
    .m_axi(axi)
  );

  always #5 clk = ~clk;

  // ---------------- slave model / monitor ----------------
  bit          aw_stall = 1'b0;
  int          bresp_err_idx = -1;
  int          bad_rd_idx = -1;
  bit          slv_clr = 1'b0;
  logic [3:0]  aw_log [32];
  logic [31:0] w_log  [32];
  logic [31:0] regs   [4];
  logic [3:0]  aw_q;
  logic [31:0] w_q;
  logic        got_aw, got_w, valid_seen;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, done_cnt, err_cnt;
  logic        aw_hs, w_hs;

  assign axi.awready = !aw_stall;
  assign axi.wready  = 1'b1;
  assign axi.arready = 1'b1;
  assign aw_hs = axi.awvalid & axi.awready;
  assign w_hs  = axi.wvalid & axi.wready;

  always @(posedge clk or posedge rst) begin
    logic [3:0]  a_v;
    logic [31:0] d_v;
    if (rst || slv_clr) begin
      axi.bvalid <= 1'b0; axi.bresp <= 2'b00;
      axi.rvalid <= 1'b0; axi.rresp <= 2'b00; axi.rdata <= 32'h0;
      got_aw <= 1'b0; got_w <= 1'b0; valid_seen <= 1'b0;
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; done_cnt <= 0; err_cnt <= 0;
    end else begin
      a_v = aw_hs ? axi.awaddr : aw_q;
      d_v = w_hs ? axi.wdata : w_q;
      if (aw_hs) begin aw_log[aw_cnt] <= axi.awaddr; aw_cnt <= aw_cnt + 1; aw_q <= axi.awaddr; end
      if (w_hs) begin w_log[w_cnt] <= axi.wdata; w_cnt <= w_cnt + 1; w_q <= axi.wdata; end
      if (axi.awvalid || axi.wvalid || axi.arvalid) valid_seen <= 1'b1;
      if (done) done_cnt <= done_cnt + 1;
      if (error) err_cnt <= err_cnt + 1;
      if (axi.bvalid && axi.bready) begin
        axi.bvalid <= 1'b0;
      end else if (!axi.bvalid && (got_aw || aw_hs) && (got_w || w_hs)) begin
        axi.bvalid <= 1'b1;
        axi.bresp  <= (b_cnt == bresp_err_idx) ? 2'b10 : 2'b00;
        regs[a_v[3:2]] <= d_v;
        b_cnt <= b_cnt + 1; got_aw <= 1'b0; got_w <= 1'b0;
      end else begin
        if (aw_hs) got_aw <= 1'b1;
        if (w_hs) got_w <= 1'b1;
      end
      if (axi.rvalid && axi.rready) begin
        axi.rvalid <= 1'b0;
      end else if (!axi.rvalid && axi.arvalid && axi.arready) begin
        axi.rvalid <= 1'b1;
        axi.rresp  <= 2'b00;
        axi.rdata  <= (ar_cnt == bad_rd_idx) ? 32'h0000DEAD : regs[axi.araddr[3:2]];
        ar_cnt <= ar_cnt + 1;
      end
    end
  end

  // ---------------- helpers (stimulus only) ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    slv_clr = 1'b1; tick(); slv_clr = 1'b0;
  endtask

  task automatic write_entry(input logic [3:0] i, input logic [3:0] a, input logic [31:0] d);
    tbl_we = 1'b1; tbl_waddr = i; tbl_wdata = {a, d}; tick(); tbl_we = 1'b0;
  endtask

  task automatic kick(input logic [4:0] n);
    num_entries = n; start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output int cyc);
    cyc = 0;
    while (!(done || error) && cyc < budget) begin tick(); cyc++; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; tbl_we = 1'b0; tbl_waddr = 4'h0; tbl_wdata = 36'h0; start = 1'b0; num_entries = 5'd0;
    repeat (3) tick();
    n_checks++; if ({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready} !== 5'b0) begin
      n_fails++; $display("FAIL reset_handshake: got %b want 00000", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}); end
    n_checks++; if ({busy, done, error, err_code, err_index} !== 9'b0) begin
      n_fails++; $display("FAIL reset_status: got %b want 0", {busy, done, error, err_code, err_index}); end
    rst = 1'b0; tick();
    n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL reset_release_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic();
    int cyc;
    for (int i = 0; i < 4; i++) write_entry(4'(i), 4'(i * 4), 32'(i + 1));
    clear_logs();
    kick(5'd4);
    n_checks++; if (busy !== 1'b1) begin n_fails++; $display("FAIL basic_busy_rise: got %b want 1", busy); end
    n_checks++; if ({axi.awprot, axi.arprot, axi.wstrb} !== 10'b0000001111) begin
      n_fails++; $display("FAIL basic_prot_strb: got %b want 0000001111", {axi.awprot, axi.arprot, axi.wstrb}); end
    wait_end(200, cyc);
    n_checks++; if ({done, error} !== 2'b10) begin n_fails++; $display("FAIL basic_done: got done/error=%b want 10", {done, error}); end
    n_checks++; if (cyc !== 4 * LAT) begin n_fails++; $display("FAIL basic_latency: got %0d want %0d", cyc, 4 * LAT); end
    tick();
    n_checks++; if (aw_cnt !== 4 || w_cnt !== 4) begin n_fails++; $display("FAIL basic_beats: got aw=%0d w=%0d want 4 4", aw_cnt, w_cnt); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (aw_log[i] !== 4'(i * 4) || w_log[i] !== 32'(i + 1)) begin
        n_fails++; $display("FAIL basic_beat%0d: got addr=%h data=%h want %h %h", i, aw_log[i], w_log[i], 4'(i * 4), 32'(i + 1)); end
    end
    n_checks++; if (done_cnt !== 1 || err_cnt !== 0) begin n_fails++; $display("FAIL basic_pulses: got done=%0d err=%0d want 1 0", done_cnt, err_cnt); end
    n_checks++; if (busy !== 1'b0 || err_code !== 2'd0) begin n_fails++; $display("FAIL basic_idle: got busy=%b code=%0d want 0 0", busy, err_code); end
`ifdef CFG_READBACK_EN
    n_checks++; if (ar_cnt !== 4) begin n_fails++; $display("FAIL basic_ar_beats: got %0d want 4", ar_cnt); end
`endif
  endtask

  task automatic test_zero();
    clear_logs();
    kick(5'd0);
    n_checks++; if ({done, busy} !== 2'b10) begin n_fails++; $display("FAIL zero_done: got done/busy=%b want 10", {done, busy}); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fails++; $display("FAIL zero_pulse_width: got %b want 0", done); end
    repeat (5) tick();
    n_checks++; if (valid_seen !== 1'b0 || done_cnt !== 1) begin
      n_fails++; $display("FAIL zero_no_valid: got valid_seen=%b done_cnt=%0d want 0 1", valid_seen, done_cnt); end
  endtask

  task automatic test_bresp_err();
    int cyc;
    clear_logs();
    bresp_err_idx = 2;
    kick(5'd4);
    wait_end(200, cyc);
    n_checks++; if ({done, error} !== 2'b01) begin n_fails++; $display("FAIL bresp_error: got done/error=%b want 01", {done, error}); end
    n_checks++; if (err_code !== 2'd1 || err_index !== 4'd2) begin
      n_fails++; $display("FAIL bresp_code: got code=%0d idx=%0d want 1 2", err_code, err_index); end
    repeat (4) tick();
    n_checks++; if (aw_cnt !== 3 || done_cnt !== 0 || busy !== 1'b0) begin
      n_fails++; $display("FAIL bresp_stop: got aw=%0d done=%0d busy=%b want 3 0 0", aw_cnt, done_cnt, busy); end
    n_checks++; if (err_code !== 2'd1 || error !== 1'b0) begin
      n_fails++; $display("FAIL bresp_hold: got code=%0d error=%b want 1 0", err_code, error); end
    bresp_err_idx = -1;
  endtask

`ifdef CFG_READBACK_EN
  task automatic test_readback_mismatch();
    int cyc;
    clear_logs();
    bad_rd_idx = 1;
    kick(5'd4);
    wait_end(200, cyc);
    n_checks++; if (error !== 1'b1 || err_code !== 2'd2 || err_index !== 4'd1) begin
      n_fails++; $display("FAIL rb_mismatch: got error=%b code=%0d idx=%0d want 1 2 1", error, err_code, err_index); end
    tick();
    n_checks++; if (aw_cnt !== 2) begin n_fails++; $display("FAIL rb_stop: got aw=%0d want 2", aw_cnt); end
    bad_rd_idx = -1;
  endtask
`endif

  task automatic test_timeout();
    int cyc;
    clear_logs();
    aw_stall = 1'b1;
    kick(5'd4);
    wait_end(400, cyc);
    // One FETCH cycle plus 256 cycles waiting in WRITE.
    n_checks++; if (error !== 1'b1 || cyc !== 257) begin n_fails++; $display("FAIL tmo_when: got error=%b cyc=%0d want 1 257", error, cyc); end
    n_checks++; if (err_code !== 2'd3 || err_index !== 4'd0) begin
      n_fails++; $display("FAIL tmo_code: got code=%0d idx=%0d want 3 0", err_code, err_index); end
    n_checks++; if ({axi.awvalid, axi.wvalid} !== 2'b00) begin
      n_fails++; $display("FAIL tmo_valid_drop: got %b want 00", {axi.awvalid, axi.wvalid}); end
    repeat (3) tick();
    n_checks++; if ({axi.awvalid, axi.wvalid, busy} !== 3'b000 || aw_cnt !== 0) begin
      n_fails++; $display("FAIL tmo_quiet: got v/b=%b aw=%0d want 000 0", {axi.awvalid, axi.wvalid, busy}, aw_cnt); end
    aw_stall = 1'b0;
  endtask

  task automatic test_async_reset();
    int cyc;
    clear_logs();
    aw_stall = 1'b1;
    kick(5'd4);
    repeat (10) tick();
    n_checks++; if ({axi.awvalid, busy} !== 2'b11) begin n_fails++; $display("FAIL ar_pre: got awvalid/busy=%b want 11", {axi.awvalid, busy}); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({axi.awvalid, axi.wvalid, busy} !== 3'b000) begin
      n_fails++; $display("FAIL ar_async_clear: got %b want 000", {axi.awvalid, axi.wvalid, busy}); end
    tick(); rst = 1'b0; aw_stall = 1'b0; tick();
    clear_logs();
    kick(5'd4);
    wait_end(200, cyc);
    n_checks++; if (done !== 1'b1) begin n_fails++; $display("FAIL ar_rerun_done: got %b want 1", done); end
    tick();
    n_checks++; if (aw_cnt !== 4 || aw_log[0] !== 4'h0) begin
      n_fails++; $display("FAIL ar_rerun_order: got aw=%0d first=%h want 4 0", aw_cnt, aw_log[0]); end
    n_checks++; if ({w_log[0], w_log[1], w_log[2], w_log[3]} !== {32'd1, 32'd2, 32'd3, 32'd4}) begin
      n_fails++; $display("FAIL ar_table_intact: got %h %h %h %h want 1 2 3 4", w_log[0], w_log[1], w_log[2], w_log[3]); end
  endtask

  task automatic test_busy_ignore();
    int cyc;
    clear_logs();
    kick(5'd4);
    tick();
    tbl_we = 1'b1; tbl_waddr = 4'h0; tbl_wdata = {4'h4, 32'h0000_0BAD};
    num_entries = 5'd1; start = 1'b1;
    tick();
    tbl_we = 1'b0; start = 1'b0;
    wait_end(200, cyc);
    n_checks++; if (done !== 1'b1) begin n_fails++; $display("FAIL busy_ign_done: got %b want 1", done); end
    tick();
    n_checks++; if (aw_cnt !== 4 || done_cnt !== 1) begin
      n_fails++; $display("FAIL busy_ign_seq: got aw=%0d done=%0d want 4 1", aw_cnt, done_cnt); end
    clear_logs();
    kick(5'd1);
    wait_end(100, cyc);
    tick();
    n_checks++; if (aw_cnt !== 1 || aw_log[0] !== 4'h0 || w_log[0] !== 32'd1) begin
      n_fails++; $display("FAIL busy_ign_table: got aw=%0d addr=%h data=%h want 1 0 1", aw_cnt, aw_log[0], w_log[0]); end
  endtask

  task automatic test_clamp();
    int cyc;
    for (int i = 4; i < 16; i++) write_entry(4'(i), 4'hC, 32'h100 + 32'(i));
    clear_logs();
    kick(5'd20);
    wait_end(600, cyc);
    n_checks++; if (done !== 1'b1 || cyc !== 16 * LAT) begin
      n_fails++; $display("FAIL clamp_done: got done=%b cyc=%0d want 1 %0d", done, cyc, 16 * LAT); end
    tick();
    n_checks++; if (aw_cnt !== 16 || w_log[15] !== 32'h10F) begin
      n_fails++; $display("FAIL clamp_beats: got aw=%0d last=%h want 16 10f", aw_cnt, w_log[15]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_bresp_err();
`ifdef CFG_READBACK_EN
    test_readback_mismatch();
`endif
    test_timeout();
    test_async_reset();
    test_busy_ignore();
    test_clamp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
